// File: rtl/rsm_controller.sv
// Moore FSM sequencing the register/ALU datapath of a small instruction set.
// Define RSM_CTRL_ILLEGAL_TRAP_EN to trap on illegal codes (otherwise they act as NOPs).
module rsm_controller #(
  parameter int unsigned NSEL_W = 3,
  parameter int unsigned RN_BIT = 0,
  parameter int unsigned RD_BIT = 1,
  parameter int unsigned RM_BIT = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  output logic              w,
  output logic [NSEL_W-1:0] nsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [NSEL_W-1:0] SEL_RN = NSEL_W'(1) << RN_BIT;
  localparam logic [NSEL_W-1:0] SEL_RD = NSEL_W'(1) << RD_BIT;
  localparam logic [NSEL_W-1:0] SEL_RM = NSEL_W'(1) << RM_BIT;

  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_SH  = 5'b110_00;
  localparam logic [4:0] I_MVN     = 5'b101_11;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_WR_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_ALU,
    ST_WR_REG
`ifdef RSM_CTRL_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] instr_q;
  logic       is_cmp, is_mov_like, retire;

  function automatic state_t decode(input logic [4:0] code);
    case (code)
      I_MOV_IMM:         return ST_WR_IMM;
      I_MOV_SH, I_MVN:   return ST_GET_B;
      I_ADD, I_CMP, I_AND: return ST_GET_A;
`ifdef RSM_CTRL_ILLEGAL_TRAP_EN
      default:           return ST_TRAP;
`else
      default:           return ST_WAIT;
`endif
    endcase
  endfunction

  assign is_cmp      = (instr_q == I_CMP);
  assign is_mov_like = (instr_q == I_MOV_SH) || (instr_q == I_MVN);
  assign retire      = (state_q == ST_WR_IMM) || (state_q == ST_WR_REG) ||
                       ((state_q == ST_ALU) && is_cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      instr_q <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_WAIT) && s) instr_q <= {opcode, op};
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    w       = 1'b0;
    nsel    = '0;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    write   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    vsel    = 2'b00;
    err     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        w = 1'b1;
        if (s) state_d = decode({opcode, op});
      end
      ST_WR_IMM: begin
        nsel    = SEL_RN;
        vsel    = 2'b10;
        write   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_GET_A: begin
        nsel    = SEL_RN;
        loada   = 1'b1;
        state_d = ST_GET_B;
      end
      ST_GET_B: begin
        nsel    = SEL_RM;
        loadb   = 1'b1;
        state_d = ST_ALU;
      end
      ST_ALU: begin
        // CMP only updates status; everything else latches C for writeback
        asel = is_mov_like;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = ST_WR_REG;
        end
      end
      ST_WR_REG: begin
        nsel    = SEL_RD;
        vsel    = 2'b00;
        write   = 1'b1;
        state_d = ST_WAIT;
      end
`ifdef RSM_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        err     = 1'b1;
        state_d = ST_TRAP;
      end
`endif
      default: state_d = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_rsm_controller.sv
// Randomized self-checking bench for rsm_controller against a per-instruction output-sequence model.
module tb_rsm_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s = 1'b0;
  logic [2:0]    opcode = '0;
  logic [1:0]    op = '0;
  logic          w, loada, loadb, loadc, loads, write, asel, bsel, err;
  logic [2:0]    nsel;
  logic [1:0]    vsel;
  logic [CW-1:0] retired;

  rsm_controller #(.NSEL_W(3), .RN_BIT(0), .RD_BIT(1), .RM_BIT(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .write(write), .asel(asel), .bsel(bsel), .vsel(vsel),
    .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef logic [13:0] ov_t;  // {w,nsel,loada,loadb,loadc,loads,write,asel,bsel,vsel,err}
  ov_t obs;
  assign obs = {w, nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel, err};

  function automatic ov_t pk(input bit wv, input bit [2:0] ns, input bit la, input bit lb,
                             input bit lc, input bit ls, input bit wr, input bit as,
                             input bit [1:0] vs, input bit er);
    return {wv, ns, la, lb, lc, ls, wr, as, 1'b0, vs, er};
  endfunction

  int  n_cmp = 0;
  int  n_bad = 0;
  int  model_ret = 0;
  ov_t exp_q[$];
  bit  exp_retire, exp_trap;
  logic [4:0] legal_codes [6] = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10101, 5'b10110};

  ov_t IDLE, GA, GB, ALU_SUM, ALU_MV, ALU_CMP, WR_RD, WR_IMM, TRAPV;

  task automatic chk(input string tag, input ov_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: outputs %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    n_cmp++;
    assert (retired === CW'(model_ret)) else begin
      n_bad++;
      $error("FAIL %s: retired %0d, expected %0d", tag, retired, model_ret);
    end
  endtask

  // Expected per-cycle outputs after acceptance, straight from each instruction's micro-op list
  task automatic build(input logic [4:0] code);
    exp_q = {};
    exp_retire = 1'b1;
    exp_trap = 1'b0;
    case (code)
      5'b11010:          exp_q = {WR_IMM};
      5'b11000, 5'b10111: exp_q = {GB, ALU_MV, WR_RD};
      5'b10100, 5'b10110: exp_q = {GA, GB, ALU_SUM, WR_RD};
      5'b10101:          exp_q = {GA, GB, ALU_CMP};
      default: begin
        exp_retire = 1'b0;
`ifdef RSM_CTRL_ILLEGAL_TRAP_EN
        exp_trap = 1'b1;
        exp_q = {TRAPV};
`endif
      end
    endcase
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_ret = 0;
    #1;
    chk({tag, "_rst_out"}, IDLE);
    chk_ret({tag, "_rst_ret"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [4:0] code, input bit poke_movimm, input string tag);
    build(code);
    @(negedge clk);
    s = 1'b1;
    {opcode, op} = code;
    foreach (exp_q[i]) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      n_cmp++;
      assert (!(write && loads)) else begin
        n_bad++;
        $error("FAIL %s_wr_ls: write=%b loads=%b, expected not both", tag, write, loads);
      end
      if (poke_movimm) begin
        s = 1'b1;
        {opcode, op} = 5'b11010;
      end else begin
        s = 1'($urandom);
        {opcode, op} = 5'($urandom);
      end
    end
    if (exp_trap) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk($sformatf("%s_trap%0d", tag, k), TRAPV);
      end
      do_reset({tag, "_trap"});
    end else begin
      @(negedge clk);
      s = 1'b0;
      if (exp_retire) model_ret = (model_ret + 1) % (1 << CW);
      chk({tag, "_done"}, IDLE);
      chk_ret({tag, "_ret"});
    end
  endtask

  initial begin
    IDLE    = pk(1, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    GA      = pk(0, 3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    GB      = pk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    ALU_SUM = pk(0, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 0);
    ALU_MV  = pk(0, 3'b000, 0, 0, 1, 0, 0, 1, 2'b00, 0);
    ALU_CMP = pk(0, 3'b000, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    WR_RD   = pk(0, 3'b010, 0, 0, 0, 0, 1, 0, 2'b00, 0);
    WR_IMM  = pk(0, 3'b001, 0, 0, 0, 0, 1, 0, 2'b10, 0);
    TRAPV   = pk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 1);

    reset = 1'b0;
    #1;
    chk("reset_out", IDLE);
    chk_ret("reset_ret");
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    chk("idle_s0", IDLE);
    run_instr(5'b11010, 1'b0, "mov_imm");
    run_instr(5'b10100, 1'b0, "add");
    run_instr(5'b10101, 1'b0, "cmp");
    run_instr(5'b10111, 1'b1, "mvn_poke");
    run_instr(5'b11000, 1'b0, "mov_sh");
    run_instr(5'b10110, 1'b0, "and");

    // Abort an ADD while it sits in ALU: nothing may be written afterwards
    @(negedge clk);
    s = 1'b1;
    {opcode, op} = 5'b10100;
    @(negedge clk);
    s = 1'b0;
    chk("abort_ga", GA);
    @(negedge clk);
    chk("abort_gb", GB);
    @(negedge clk);
    chk("abort_alu", ALU_SUM);
    #2;
    do_reset("abort");
    @(negedge clk);
    chk("abort_post1", IDLE);
    @(negedge clk);
    chk("abort_post2", IDLE);
    chk_ret("abort_post_ret");

    run_instr(5'b11111, 1'b0, "illegal");
    run_instr(5'b11010, 1'b0, "after_illegal");

    for (int n = 0; n < 40; n++) begin
      logic [4:0] code;
      if ($urandom_range(7) == 0) code = 5'($urandom);
      else code = legal_codes[$urandom_range(5)];
      run_instr(code, 1'b0, $sformatf("rnd%0d_%b", n, code));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
